fifo_read_packer: RTL

- Drain stage on the read side of the dual-clock FIFO, running in the rclk domain.
- Pops DSIZE-bit entries whenever the FIFO is non-empty and packs WORDS consecutive entries into one wide word.
- Presents each packed word to a downstream consumer over a valid/ready handshake.
- A flush input forces out a partially filled word, so the tail of a burst is not stranded.

---
 rtl/fifo_read_packer_if.sv | 29 ++
 rtl/fifo_read_packer.sv | 103 ++++++++++
 2 files changed

// File: rtl/fifo_read_packer_if.sv
// fifo_read_packer_if: FIFO read-side and packed-word handshake signals.
// The master modport is the packer; the slave modport is its environment.
interface fifo_read_packer_if #(
  parameter int DSIZE = 8,
  parameter int WORDS = 4,
  parameter int CSIZE = 16
);
  localparam int CW = $clog2(WORDS) + 1;

  logic [DSIZE-1:0]       rdata;
  logic                   rempty;
  logic                   rinc;
  logic                   flush;
  logic [DSIZE*WORDS-1:0] out_data;
  logic [CW-1:0]          out_cnt;
  logic                   out_valid;
  logic                   out_ready;
  logic [CSIZE-1:0]       word_count;

  modport master (
    input  rdata, rempty, flush, out_ready,
    output rinc, out_data, out_cnt, out_valid, word_count
  );

  modport slave (
    output rdata, rempty, flush, out_ready,
    input  rinc, out_data, out_cnt, out_valid, word_count
  );
endinterface

// File: rtl/fifo_read_packer.sv
// fifo_read_packer: drains a show-ahead FIFO in the rclk domain, packs WORDS
// consecutive entries into one wide word and offers it over valid/ready.
// A flush pulse emits a partially filled word.
// Optional build macro PACK_BIG_ENDIAN_EN: slot 0 lands in the top DSIZE bits
// and partial words are left-aligned; otherwise slot 0 is in the low bits.
module fifo_read_packer #(
  parameter int DSIZE = 8,
  parameter int WORDS = 4,
  parameter int CSIZE = 16
) (
  input  logic               rclk,
  input  logic               rrst,
  fifo_read_packer_if.master bus
);
  localparam int IW = $clog2(WORDS);
  localparam int CW = $clog2(WORDS) + 1;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                      state_q;
  logic [IW-1:0]               idx_q;
  logic [WORDS-1:0][DSIZE-1:0] slots_q;
  logic [WORDS-1:0][DSIZE-1:0] slots_d;
  logic [DSIZE*WORDS-1:0]      out_data_q;
  logic [DSIZE*WORDS-1:0]      out_data_d;
  logic [CW-1:0]               out_cnt_q;
  logic [CW-1:0]               out_cnt_d;
  logic                        out_valid_q;
  logic [CSIZE-1:0]            word_count_q;
  logic                        pop;
  logic                        emit;

  // Pop decision, slot update with the entry being popped, and packed view.
  always_comb begin
    pop      = (state_q == FILL) && !bus.rempty && !rrst;
    bus.rinc = pop;

    slots_d = slots_q;
    if (pop) begin
      slots_d[idx_q] = bus.rdata;
    end

    // Unused slots are zero because the slot store is cleared at handshake.
    out_data_d = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
`ifdef PACK_BIG_ENDIAN_EN
      out_data_d[(WORDS - 1 - i) * DSIZE +: DSIZE] = slots_d[i];
`else
      out_data_d[i * DSIZE +: DSIZE] = slots_d[i];
`endif
    end

    out_cnt_d = pop ? CW'(idx_q) + CW'(1) : CW'(idx_q);

    // A full word or a flush with at least one entry (held or being popped).
    emit = (state_q == FILL) &&
           ((pop && (idx_q == IW'(WORDS - 1))) ||
            (bus.flush && (pop || (idx_q != '0))));
  end

  // FILL/HOLD state machine with registered handshake outputs.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q      <= FILL;
      idx_q        <= '0;
      slots_q      <= '0;
      out_data_q   <= '0;
      out_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          slots_q <= slots_d;
          if (pop) begin
            idx_q <= idx_q + IW'(1);
          end
          if (emit) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_cnt_q   <= out_cnt_d;
            out_data_q  <= out_data_d;
            idx_q       <= '0;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q      <= FILL;
            out_valid_q  <= 1'b0;
            slots_q      <= '0;
            word_count_q <= word_count_q + CSIZE'(1);
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_cnt    = out_cnt_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.word_count = word_count_q;
endmodule
